lsu_bus_ctrl: RTL and testbench
===============================

Name: lsu_bus_ctrl

Overview:
- Parametrised second-generation load-store unit for the single-cycle RV32I core. It decodes each core access into one of three regions: data memory, peripheral space (output/input buffers) or unmapped.
- Data memory is reached through a variable-latency req/ack bus, for example the 32b SRAM controller, and the core is stalled until the access completes.
- Improvements over the previous LSU:
  - true sub-word alignment on loads and stores (byte lanes chosen by addr[1:0]);
  - byte strobes instead of read-modify-write;
  - misalignment and unmapped-access detection;
  - bus timeout with sticky error status.

Parameters:
- DMEM_BASE, 32'h0000_2000, byte base address of the data-memory region.
- DMEM_SIZE, 32'h0000_0400, region size in bytes (power of two).
- PER_BASE, 32'h0000_7000, byte base address of the peripheral region.
- PER_SIZE, 32'h0000_1000, peripheral region size in bytes (power of two).
- MEM_AW, 18, width of the memory-bus word address.
- PER_AW, 12, width of the peripheral byte offset.
- TIMEOUT, 16, number of cycles o_mem_req may stay high without ack before abort (≥2).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  core access valid; held stable by the core while o_stall=1.
- i_lsu_wren  in  1  1=store, 0=load.
- i_lsu_op  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are invalid.
- i_lsu_addr  in  32  byte address.
- i_st_data  in  32  store data, right-aligned.
- i_err_clr  in  1  clears o_err_sticky.
- o_ld_data  out  32  aligned, extended load result.
- o_stall  out  1  freeze core PC/writeback.
- o_done  out  1  access completes this cycle.
- o_err  out  2  error of the completing access: 00 none, 01 misaligned/invalid op, 10 unmapped, 11 timeout.
- o_err_sticky  out  2  first error latched since clear.
- o_mem_req  out  1  memory bus request (registered).
- o_mem_wren  out  1  memory bus write.
- o_mem_addr  out  MEM_AW  word address = (addr-DMEM_BASE)>>2.
- o_mem_wdata  out  32  lane-replicated store data.
- o_mem_bmask  out  4  byte strobes.
- i_mem_ack  in  1  memory bus completion, one-cycle pulse.
- i_mem_rdata  in  32  read word, valid with ack.
- o_per_sel  out  1  peripheral access strobe (combinational).
- o_per_wren  out  1  peripheral write (combinational).
- o_per_addr  out  PER_AW  byte offset from PER_BASE.
- o_per_wdata  out  32  lane-replicated store data.
- o_per_bmask  out  4  byte strobes.
- i_per_rdata  in  32  peripheral read word, same-cycle.

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - state=IDLE; o_mem_req=0, o_mem_wren=0, o_mem_addr=0, o_mem_wdata=0, o_mem_bmask=0;
  - timeout counter=0, read capture=0, o_err_sticky=00;
  - combinational outputs settle to 0 with i_req=0.
- Lane rules, from addr[1:0]:
  - Byte: bmask=0001<<a[1:0]; wdata={4{st[7:0]}}.
  - Half: bmask=0011<<(2*a[1]); wdata={2{st[15:0]}}.
  - Word: bmask=1111; wdata=st.
  - Load extraction: B/BU take rdata[8*a[1:0]+:8]; H/HU take rdata[16*a[1]+:16]; result is sign- or zero-extended per op.
- Error checks, in priority order:
  - misaligned (H/HU with a[0]=1, W with a[1:0]≠0) or invalid op → 01;
  - otherwise address outside both regions → 10.
- FSM states: IDLE, MEM, RESP.
- IDLE:
  - i_req=0: no activity, o_done=0.
  - i_req with error: o_done=1 and o_err=code in the same cycle; no bus activity; o_ld_data=0; o_stall=0.
  - i_req to peripheral: o_per_sel=1 and o_per_wren=i_lsu_wren in the same cycle; load returns extracted i_per_rdata combinationally; o_done=1; o_stall=0; single-cycle access.
  - i_req to data memory: o_stall=1; register addr/wdata/bmask/wren; o_mem_req←1; go to MEM.
- MEM:
  - o_stall=1; o_mem_req stays high with stable fields; counter increments each cycle.
  - i_mem_ack → capture i_mem_rdata, drop o_mem_req, go to RESP.
  - No ack and counter=TIMEOUT-1 → drop o_mem_req, capture 0, flag timeout, go to RESP.
  - Ack in the timeout cycle: ack wins and the access is not flagged.
- RESP:
  - o_stall=0, o_done=1; o_ld_data from the capture register (0 for stores); o_err=00 or 11.
  - Always go to IDLE; i_req is not re-sampled in this cycle.
- Minimum data-memory latency is 3 cycles (IDLE, MEM with ack, RESP).
- i_mem_ack outside MEM is ignored.
- o_err_sticky:
  - loads the code of the first nonzero o_err when it is 00;
  - i_err_clr has priority over a same-cycle load.
- Region decoding uses the full 32-bit address; regions are [BASE, BASE+SIZE).

Test Plan:
- LW 0x2004 with ack 2 cycles after req, rdata=0xDEADBEEF → o_stall high 3 cycles; o_mem_addr=1; o_ld_data=0xDEADBEEF in the RESP cycle.
- LB 0x2003 with rdata=0x80FF0011, then LBU on the same word → 0xFFFFFF80, then 0x00000080; LH 0x2002 on the same word → 0xFFFF80FF.
- SB 0x7001, st=0x000000A5 → same cycle o_per_sel=1, o_per_wren=1, o_per_bmask=0010, o_per_wdata=0xA5A5A5A5, o_per_addr=0x001, no stall.
- SW 0x2002 → o_err=01, o_done=1, no o_mem_req; then LW 0x5000 → o_err=10; o_err_sticky=01 until i_err_clr.
- LW 0x2000 with no ack → o_mem_req high exactly TIMEOUT cycles; RESP shows o_err=11, o_ld_data=0; repeat with ack in cycle TIMEOUT-1 → no error.
- Assert i_rst_n=0 mid-MEM → o_mem_req and o_stall drop immediately; a late ack after reset has no effect.

Source files
------------

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: RV32I load-store unit that routes accesses to a req/ack data-memory bus, a same-cycle peripheral port, or an error response
module lsu_bus_ctrl #(
  parameter logic [31:0] DMEM_BASE = 32'h0000_2000,
  parameter logic [31:0] DMEM_SIZE = 32'h0000_0400,
  parameter logic [31:0] PER_BASE  = 32'h0000_7000,
  parameter logic [31:0] PER_SIZE  = 32'h0000_1000,
  parameter int          MEM_AW    = 18,
  parameter int          PER_AW    = 12,
  parameter int          TIMEOUT   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_lsu_wren,
  input  logic [2:0]        i_lsu_op,
  input  logic [31:0]       i_lsu_addr,
  input  logic [31:0]       i_st_data,
  input  logic              i_err_clr,
  output logic [31:0]       o_ld_data,
  output logic              o_stall,
  output logic              o_done,
  output logic [1:0]        o_err,
  output logic [1:0]        o_err_sticky,
  output logic              o_mem_req,
  output logic              o_mem_wren,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_per_sel,
  output logic              o_per_wren,
  output logic [PER_AW-1:0] o_per_addr,
  output logic [31:0]       o_per_wdata,
  output logic [3:0]        o_per_bmask,
  input  logic [31:0]       i_per_rdata
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
  state_t r_state, w_next;
  logic [31:0] w_doff, w_poff, w_wdata, r_rdata;
  logic [1:0] w_a, w_err, r_lane;
  logic [3:0] w_bmask;
  logic [2:0] r_op;
  logic [CW-1:0] r_cnt;
  logic w_is_b, w_is_h, w_is_w, w_misal, w_in_dmem, w_in_per;
  logic w_idle_req, w_ok, w_go_mem, w_ack, w_tout, r_tout;
  function automatic logic [31:0] f_extract(input logic [31:0] d, input logic [2:0] op, input logic [1:0] a);
    logic [7:0] b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = d[{a[1], 4'b0000} +: 16];
    return op[1] ? d : op[0] ? {{16{h[15] & ~op[2]}}, h} : {{24{b[7] & ~op[2]}}, b};
  endfunction
  assign w_a       = i_lsu_addr[1:0];
  assign w_doff    = i_lsu_addr - DMEM_BASE;
  assign w_poff    = i_lsu_addr - PER_BASE;
  assign w_in_dmem = w_doff < DMEM_SIZE;
  assign w_in_per  = w_poff < PER_SIZE;
  assign w_is_b    = i_lsu_op[1:0] == 2'b00;
  assign w_is_h    = i_lsu_op[1:0] == 2'b01;
  assign w_is_w    = i_lsu_op == 3'b010;
  assign w_misal   = !(w_is_b || w_is_h || w_is_w) || (w_is_h && w_a[0]) || (w_is_w && |w_a);
  assign w_err     = w_misal ? 2'b01 : (!w_in_dmem && !w_in_per) ? 2'b10 : 2'b00;
  assign w_bmask   = w_is_w ? 4'b1111 : w_is_h ? (w_a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << w_a;
  assign w_wdata   = w_is_w ? i_st_data : w_is_h ? {2{i_st_data[15:0]}} : {4{i_st_data[7:0]}};
  assign w_idle_req = r_state == IDLE && i_req;
  assign w_ok       = w_idle_req && w_err == 2'b00;
  assign w_go_mem   = w_ok && w_in_dmem;
  assign w_ack      = r_state == MEM && i_mem_ack;
  // ack in the final counted cycle beats the timeout
  assign w_tout     = r_state == MEM && !i_mem_ack && r_cnt == CW'(TIMEOUT - 1);
  assign o_per_sel   = w_ok && !w_in_dmem;
  assign o_per_wren  = o_per_sel && i_lsu_wren;
  assign o_per_addr  = o_per_sel ? w_poff[PER_AW-1:0] : '0;
  assign o_per_wdata = o_per_sel ? w_wdata : '0;
  assign o_per_bmask = o_per_sel ? w_bmask : '0;
  assign o_stall = w_go_mem || r_state == MEM;
  assign o_done  = (w_idle_req && !w_go_mem) || r_state == RESP;
  assign o_err   = w_idle_req ? w_err : (r_state == RESP && r_tout) ? 2'b11 : 2'b00;
  assign o_ld_data = (o_per_sel && !i_lsu_wren) ? f_extract(i_per_rdata, i_lsu_op, w_a) :
                     (r_state == RESP && !o_mem_wren) ? f_extract(r_rdata, r_op, r_lane) : '0;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_go_mem ? MEM : IDLE) :
             (r_state == MEM)  ? ((w_ack || w_tout) ? RESP : MEM) : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_req    <= 1'b0;
      o_mem_wren   <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_mem_bmask  <= '0;
      r_op         <= '0;
      r_lane       <= '0;
      r_cnt        <= '0;
      r_tout       <= 1'b0;
      r_rdata      <= '0;
      o_err_sticky <= 2'b00;
    end else begin
      if (w_go_mem) begin
        o_mem_req   <= 1'b1;
        o_mem_wren  <= i_lsu_wren;
        o_mem_addr  <= w_doff[MEM_AW+1:2];
        o_mem_wdata <= w_wdata;
        o_mem_bmask <= w_bmask;
        r_op        <= i_lsu_op;
        r_lane      <= w_a;
        r_cnt       <= '0;
        r_tout      <= 1'b0;
        r_rdata     <= '0;
      end else if (r_state == MEM) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_ack || w_tout) begin
          o_mem_req <= 1'b0;
          r_rdata   <= w_ack ? i_mem_rdata : '0;
          r_tout    <= w_tout;
        end
      end
      o_err_sticky <= i_err_clr ? 2'b00 : (o_err_sticky == 2'b00) ? o_err : o_err_sticky;
    end
  end
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: directed checks of lsu_bus_ctrl lane handling, region decode, errors, timeout and reset
module tb_lsu_bus_ctrl;
  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_req = 1'b0, i_lsu_wren = 1'b0, i_err_clr = 1'b0;
  logic [2:0]  i_lsu_op = 3'b000;
  logic [31:0] i_lsu_addr = '0, i_st_data = '0, i_mem_rdata = '0, i_per_rdata = '0;
  logic        i_mem_ack = 1'b0;
  logic [31:0] o_ld_data, o_mem_wdata, o_per_wdata;
  logic        o_stall, o_done, o_mem_req, o_mem_wren, o_per_sel, o_per_wren;
  logic [1:0]  o_err, o_err_sticky;
  logic [17:0] o_mem_addr;
  logic [11:0] o_per_addr;
  logic [3:0]  o_mem_bmask, o_per_bmask;
  int n_chk = 0, n_fail = 0;
  int t_stalls, t_reqs;
  logic [31:0] t_ld, t_wdata, t_maddr;
  logic [3:0]  t_bmask;
  logic [1:0]  t_err;
  logic        t_mwren;

  lsu_bus_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_lsu_wren(i_lsu_wren),
    .i_lsu_op(i_lsu_op), .i_lsu_addr(i_lsu_addr), .i_st_data(i_st_data), .i_err_clr(i_err_clr),
    .o_ld_data(o_ld_data), .o_stall(o_stall), .o_done(o_done), .o_err(o_err),
    .o_err_sticky(o_err_sticky), .o_mem_req(o_mem_req), .o_mem_wren(o_mem_wren),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_per_sel(o_per_sel),
    .o_per_wren(o_per_wren), .o_per_addr(o_per_addr), .o_per_wdata(o_per_wdata),
    .o_per_bmask(o_per_bmask), .i_per_rdata(i_per_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] st);
    i_req = 1'b1; i_lsu_wren = w; i_lsu_op = op; i_lsu_addr = a; i_st_data = st;
  endtask

  task automatic do_mem(input logic w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] st,
                        input int ack_at, input logic [31:0] rd);
    logic seen;
    seen = 1'b0;
    t_stalls = 0; t_reqs = 0; t_ld = 'x; t_err = 'x; t_maddr = 'x; t_bmask = 'x; t_wdata = 'x; t_mwren = 1'bx;
    drive(w, op, a, st);
    for (int c = 0; c < 40 && !seen; c++) begin
      i_mem_ack = (c == ack_at);
      i_mem_rdata = (c == ack_at) ? rd : 32'h0;
      #2;
      if (o_stall) t_stalls++;
      if (o_mem_req) begin
        t_reqs++; t_maddr = 32'(o_mem_addr); t_bmask = o_mem_bmask; t_wdata = o_mem_wdata; t_mwren = o_mem_wren;
      end
      if (o_done) begin seen = 1'b1; t_ld = o_ld_data; t_err = o_err; end
      next_cyc();
    end
    i_req = 1'b0; i_mem_ack = 1'b0;
    chk("done_within_bound", 32'(seen), 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_mem_req", 32'(o_mem_req), 0);
    chk("rst_stall", 32'(o_stall), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_sticky", 32'(o_err_sticky), 0);
    chk("rst_mem_addr", 32'(o_mem_addr), 0);
    chk("rst_ld", o_ld_data, 0);
    #11 i_rst_n = 1'b1;
    next_cyc();
    // LW 0x2004, ack in the second MEM cycle
    do_mem(1'b0, 3'b010, 32'h2004, 0, 2, 32'hDEADBEEF);
    chk("lw_stalls", t_stalls, 3);
    chk("lw_reqs", t_reqs, 2);
    chk("lw_maddr", t_maddr, 1);
    chk("lw_bmask", 32'(t_bmask), 32'hF);
    chk("lw_data", t_ld, 32'hDEADBEEF);
    chk("lw_err", 32'(t_err), 0);
    do_mem(1'b0, 3'b000, 32'h2003, 0, 1, 32'h80FF0011);
    chk("lb_data", t_ld, 32'hFFFFFF80);
    chk("lb_stalls", t_stalls, 2);
    do_mem(1'b0, 3'b100, 32'h2003, 0, 1, 32'h80FF0011);
    chk("lbu_data", t_ld, 32'h00000080);
    do_mem(1'b0, 3'b001, 32'h2002, 0, 1, 32'h80FF0011);
    chk("lh_data", t_ld, 32'hFFFF80FF);
    do_mem(1'b0, 3'b101, 32'h2000, 0, 1, 32'h80FF9001);
    chk("lhu_lo_data", t_ld, 32'h00009001);
    do_mem(1'b1, 3'b001, 32'h2002, 32'h00001234, 1, 32'hFFFFFFFF);
    chk("sh_bmask", 32'(t_bmask), 32'hC);
    chk("sh_wdata", t_wdata, 32'h12341234);
    chk("sh_wren", 32'(t_mwren), 1);
    chk("sh_ld_zero", t_ld, 0);
    do_mem(1'b1, 3'b000, 32'h2001, 32'h000000A5, 1, 0);
    chk("sb_bmask", 32'(t_bmask), 32'h2);
    chk("sb_wdata", t_wdata, 32'hA5A5A5A5);
    do_mem(1'b0, 3'b010, 32'h23FC, 0, 1, 32'h11223344);
    chk("lw_top_maddr", t_maddr, 32'hFF);
    chk("lw_top_data", t_ld, 32'h11223344);
    // peripheral store, single cycle
    drive(1'b1, 3'b000, 32'h7001, 32'h000000A5);
    #2;
    chk("psb_sel", 32'(o_per_sel), 1);
    chk("psb_wren", 32'(o_per_wren), 1);
    chk("psb_bmask", 32'(o_per_bmask), 32'h2);
    chk("psb_wdata", o_per_wdata, 32'hA5A5A5A5);
    chk("psb_addr", 32'(o_per_addr), 1);
    chk("psb_stall", 32'(o_stall), 0);
    chk("psb_done", 32'(o_done), 1);
    chk("psb_err", 32'(o_err), 0);
    next_cyc();
    i_per_rdata = 32'h80011234;
    drive(1'b0, 3'b001, 32'h7002, 0);
    #2;
    chk("plh_data", o_ld_data, 32'hFFFF8001);
    chk("plh_wren", 32'(o_per_wren), 0);
    i_lsu_op = 3'b101;
    #1;
    chk("plhu_data", o_ld_data, 32'h00008001);
    next_cyc();
    drive(1'b0, 3'b000, 32'h7FFF, 0);
    #2;
    chk("plb_top_addr", 32'(o_per_addr), 32'hFFF);
    chk("plb_top_data", o_ld_data, 32'hFFFFFF80);
    chk("plb_top_mem_req", 32'(o_mem_req), 0);
    next_cyc();
    i_req = 1'b0;
    #2;
    chk("idle_per_sel", 32'(o_per_sel), 0);
    chk("idle_done", 32'(o_done), 0);
    // error responses and sticky status
    next_cyc();
    drive(1'b1, 3'b010, 32'h2002, 32'h12345678);
    #2;
    chk("sw_mis_err", 32'(o_err), 1);
    chk("sw_mis_done", 32'(o_done), 1);
    chk("sw_mis_stall", 32'(o_stall), 0);
    next_cyc();
    i_req = 1'b0;
    #2;
    chk("sw_mis_no_req", 32'(o_mem_req), 0);
    chk("sticky_01", 32'(o_err_sticky), 1);
    next_cyc();
    drive(1'b0, 3'b010, 32'h5000, 0);
    #2;
    chk("unmapped_err", 32'(o_err), 2);
    chk("unmapped_ld", o_ld_data, 0);
    next_cyc();
    i_req = 1'b0;
    #2;
    chk("sticky_keeps_first", 32'(o_err_sticky), 1);
    drive(1'b0, 3'b000, 32'h2400, 0);
    #1;
    chk("dmem_end_unmapped", 32'(o_err), 2);
    i_lsu_addr = 32'h1FFF;
    #1;
    chk("below_dmem_unmapped", 32'(o_err), 2);
    i_lsu_addr = 32'h8000;
    #1;
    chk("per_end_unmapped", 32'(o_err), 2);
    i_req = 1'b0;
    i_err_clr = 1'b1;
    next_cyc();
    i_err_clr = 1'b0;
    #2;
    chk("sticky_cleared", 32'(o_err_sticky), 0);
    drive(1'b0, 3'b011, 32'h2000, 0);
    i_err_clr = 1'b1;
    #2;
    chk("bad_op_err", 32'(o_err), 1);
    next_cyc();
    i_req = 1'b0; i_err_clr = 1'b0;
    #2;
    chk("clr_wins", 32'(o_err_sticky), 0);
    next_cyc();
    // timeout, then ack in the last allowed cycle
    do_mem(1'b0, 3'b010, 32'h2000, 0, -1, 0);
    chk("to_reqs", t_reqs, 16);
    chk("to_stalls", t_stalls, 17);
    chk("to_err", 32'(t_err), 3);
    chk("to_ld", t_ld, 0);
    chk("to_sticky", 32'(o_err_sticky), 3);
    do_mem(1'b0, 3'b010, 32'h2000, 0, 16, 32'h5A5A0F0F);
    chk("late_ack_reqs", t_reqs, 16);
    chk("late_ack_err", 32'(t_err), 0);
    chk("late_ack_ld", t_ld, 32'h5A5A0F0F);
    // reset in the middle of a memory access
    drive(1'b0, 3'b010, 32'h2008, 0);
    next_cyc();
    #2;
    chk("mid_mem_req", 32'(o_mem_req), 1);
    i_rst_n = 1'b0; i_req = 1'b0;
    #1;
    chk("arst_mem_req", 32'(o_mem_req), 0);
    chk("arst_stall", 32'(o_stall), 0);
    chk("arst_sticky", 32'(o_err_sticky), 0);
    chk("arst_mem_addr", 32'(o_mem_addr), 0);
    #2 i_rst_n = 1'b1;
    i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFEF00D;
    next_cyc();
    i_mem_ack = 1'b0;
    #2;
    chk("stray_ack_done", 32'(o_done), 0);
    chk("stray_ack_ld", o_ld_data, 0);
    chk("stray_ack_req", 32'(o_mem_req), 0);
    chk("stray_ack_stall", 32'(o_stall), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
